comparator_checker: RTL and testbench
=====================================

COMPARATOR_CHECKER -- requirements
Module: comparator_checker

Interface
REQ-001 SHALL have parameter OPERATOR_WIDTH, default 512, width of each operand.
REQ-002 SHALL have parameter LIMB_WIDTH, default 64, width of one compare step; OPERATOR_WIDTH SHALL be an integer multiple of LIMB_WIDTH; N = OPERATOR_WIDTH/LIMB_WIDTH.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 iClk  input  1  sole clock, rising edge.
REQ-005 iRstN  input  1  asynchronous active-low reset.
REQ-006 iValid  input  1  operand/result triple offered.
REQ-007 oReady  output  1  checker can accept a triple.
REQ-008 iA  input  OPERATOR_WIDTH  operand A, unsigned.
REQ-009 iB  input  OPERATOR_WIDTH  operand B, unsigned.
REQ-010 iDutRes  input  3  comparator-under-test result: bit2 A>B, bit1 A==B, bit0 A<B.
REQ-011 iClear  input  1  synchronous clear of counters and signature.
REQ-012 oDone  output  1  one-cycle pulse, check complete.
REQ-013 oMismatch  output  1  valid with oDone; 1 = iDutRes differed from reference.
REQ-014 oErrCnt  output  16  saturating mismatch count.
REQ-015 oCheckCnt  output  16  wrapping completed-check count.
REQ-016 oSignature  output  16  MISR over reference results.

Function
REQ-017 SHALL implement FSM states IDLE, COMPARE, CHECK; oReady = 1 only in IDLE; oDone = 1 only in CHECK.
REQ-018 Handshake SHALL occur on a rising edge with iValid=1 and oReady=1; iA, iB, iDutRes SHALL be captured at that edge and FSM SHALL go IDLE->COMPARE.
REQ-019 iValid while oReady=0 SHALL be ignored; inputs need not be held after the handshake.
REQ-020 COMPARE SHALL examine one LIMB_WIDTH limb per cycle, most significant limb first, index k=0..N-1.
REQ-021 On the first limb with A!=B, the reference result SHALL be 3'b100 (A limb greater) or 3'b001, and FSM SHALL go COMPARE->CHECK.
REQ-022 If all N limbs are equal, the reference result SHALL be 3'b010 and FSM SHALL go COMPARE->CHECK after limb N-1.
REQ-023 Latency: handshake at edge T; oDone high in cycle T+k+2 for first differing limb k, T+N+1 for equal operands.
REQ-024 CHECK SHALL last exactly one cycle, then go to IDLE; oMismatch = (reference != captured iDutRes) during CHECK, 0 otherwise.
REQ-025 Illegal DUT codes (not one-hot) SHALL count as mismatches.
REQ-026 At the edge ending CHECK: oCheckCnt += 1 (wraps 16'hFFFF->0); oErrCnt += oMismatch, saturating at 16'hFFFF.
REQ-027 At the same edge oSignature SHALL become {sig[14:0], sig[15]^sig[13]^sig[12]^sig[10]} XOR {13'b0, reference}.
REQ-028 iClear=1 SHALL zero oErrCnt, oCheckCnt, oSignature at the next edge, taking priority over a simultaneous CHECK update; FSM and in-flight compare unaffected.
REQ-029 Unused states SHALL recover to IDLE on the next edge.

Reset
REQ-030 iRstN=0 SHALL immediately force FSM to IDLE, oDone=0, oMismatch=0, oErrCnt=0, oCheckCnt=0, oSignature=0; oReady=1 (IDLE).
REQ-031 Reset asserted mid-COMPARE or in CHECK SHALL discard the in-flight check with no counter or signature update.
REQ-032 First handshake SHALL be possible on the first rising edge after iRstN deasserts.

Verification (OPERATOR_WIDTH=512, LIMB_WIDTH=64, N=8)
REQ-033 A=B=0, iDutRes=3'b010 -> oDone at T+9, oMismatch=0, oCheckCnt=1, oErrCnt=0, oSignature=16'h0002.
REQ-034 Then A=0, B=1, iDutRes=3'b001 -> oDone at T+9, oMismatch=0, oSignature=16'h0005, oCheckCnt=2.
REQ-035 A limb0=1 else 0, B=0, iDutRes=3'b100 -> oDone at T+2, oMismatch=0, oReady high at T+3.
REQ-036 A=5, B=6, iDutRes=3'b100 -> oDone at T+9, oMismatch=1, oErrCnt=1; repeat with iDutRes=3'b110 -> oErrCnt=2.
REQ-037 iValid held high continuously -> handshakes only when oReady=1, exactly one oDone per handshake, no captures during COMPARE/CHECK.
REQ-038 iRstN pulsed low at T+4 of an equal-operand check -> no oDone, all counters 0, oReady=1; iClear coincident with CHECK -> counters 0 afterwards.

Source files
------------

// File: rtl/comparator_checker.sv
// Checks a magnitude comparator's result against a limb-serial reference compare.
// Keeps a mismatch count, a completed-check count and a MISR signature over the reference results.
module comparator_checker #(
  parameter int unsigned OPERATOR_WIDTH = 512,
  parameter int unsigned LIMB_WIDTH     = 64
) (
  input  logic                      iClk,
  input  logic                      iRstN,
  input  logic                      iValid,
  output logic                      oReady,
  input  logic [OPERATOR_WIDTH-1:0] iA,
  input  logic [OPERATOR_WIDTH-1:0] iB,
  input  logic [2:0]                iDutRes,
  input  logic                      iClear,
  output logic                      oDone,
  output logic                      oMismatch,
  output logic [15:0]               oErrCnt,
  output logic [15:0]               oCheckCnt,
  output logic [15:0]               oSignature
);

  localparam int unsigned N      = OPERATOR_WIDTH / LIMB_WIDTH;
  localparam int unsigned K_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    CHECK   = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [OPERATOR_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]                dut_q, dut_d, ref_q, ref_d;
  logic [K_W-1:0]            k_q, k_d;
  logic                      ready_q, ready_d, done_q, done_d, mismatch_q, mismatch_d;
  logic [15:0]               err_q, err_d, chk_q, chk_d, sig_q, sig_d;
  logic [LIMB_WIDTH-1:0]     a_limb, b_limb;

  // Operands shift left each cycle so the limb under test is always the top one.
  assign a_limb = a_q[OPERATOR_WIDTH-1 -: LIMB_WIDTH];
  assign b_limb = b_q[OPERATOR_WIDTH-1 -: LIMB_WIDTH];

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    dut_d      = dut_q;
    ref_d      = ref_q;
    k_d        = k_q;
    ready_d    = 1'b0;
    done_d     = 1'b0;
    mismatch_d = 1'b0;
    err_d      = err_q;
    chk_d      = chk_q;
    sig_d      = sig_q;

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (iValid) begin
          a_d     = iA;
          b_d     = iB;
          dut_d   = iDutRes;
          k_d     = '0;
          state_d = COMPARE;
          ready_d = 1'b0;
        end
      end
      COMPARE: begin
        a_d = a_q << LIMB_WIDTH;
        b_d = b_q << LIMB_WIDTH;
        if (a_limb != b_limb) begin
          ref_d      = (a_limb > b_limb) ? 3'b100 : 3'b001;
          state_d    = CHECK;
          done_d     = 1'b1;
          mismatch_d = (ref_d != dut_q);
        end else if (k_q == K_LAST) begin
          ref_d      = 3'b010;
          state_d    = CHECK;
          done_d     = 1'b1;
          mismatch_d = (ref_d != dut_q);
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      CHECK: begin
        state_d = IDLE;
        ready_d = 1'b1;
        chk_d   = chk_q + 16'd1;
        if (mismatch_q && (err_q != '1)) err_d = err_q + 16'd1;
        sig_d   = {sig_q[14:0], sig_q[15] ^ sig_q[13] ^ sig_q[12] ^ sig_q[10]} ^ {13'b0, ref_q};
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase

    if (iClear) begin
      err_d = '0;
      chk_d = '0;
      sig_d = '0;
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      dut_q      <= '0;
      ref_q      <= '0;
      k_q        <= '0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      mismatch_q <= 1'b0;
      err_q      <= '0;
      chk_q      <= '0;
      sig_q      <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      dut_q      <= dut_d;
      ref_q      <= ref_d;
      k_q        <= k_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
      chk_q      <= chk_d;
      sig_q      <= sig_d;
    end
  end

  assign oReady     = ready_q;
  assign oDone      = done_q;
  assign oMismatch  = mismatch_q;
  assign oErrCnt    = err_q;
  assign oCheckCnt  = chk_q;
  assign oSignature = sig_q;

endmodule

// File: tb/tb_comparator_checker.sv
// Scoreboard bench for comparator_checker: stimulus queues expected results, a monitor checks each oDone.
module tb_comparator_checker;

  localparam int unsigned W = 512;
  localparam int unsigned L = 64;

  logic          iClk = 1'b0;
  logic          iRstN = 1'b0;
  logic          iValid = 1'b0;
  logic          oReady;
  logic [W-1:0]  iA = '0;
  logic [W-1:0]  iB = '0;
  logic [2:0]    iDutRes = '0;
  logic          iClear = 1'b0;
  logic          oDone, oMismatch;
  logic [15:0]   oErrCnt, oCheckCnt, oSignature;

  comparator_checker #(.OPERATOR_WIDTH(W), .LIMB_WIDTH(L)) dut (
    .iClk(iClk), .iRstN(iRstN), .iValid(iValid), .oReady(oReady),
    .iA(iA), .iB(iB), .iDutRes(iDutRes), .iClear(iClear),
    .oDone(oDone), .oMismatch(oMismatch), .oErrCnt(oErrCnt),
    .oCheckCnt(oCheckCnt), .oSignature(oSignature)
  );

  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  typedef struct {
    int          done_cyc;
    logic        mm;
    logic [15:0] err;
    logic [15:0] chk;
    logic [15:0] sig;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  logic [15:0] m_err = '0, m_chk = '0, m_sig = '0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Offers one triple and returns the label of the cycle following the handshake edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] res,
                       input int lat, input bit push, input logic mm,
                       input logic [15:0] e_err, input logic [15:0] e_chk, input logic [15:0] e_sig,
                       output int c);
    int n = 0;
    exp_t e;
    while (!oReady && n < 100) begin
      @(negedge iClk);
      n++;
    end
    if (!oReady) check("ready_timeout", {63'd0, oReady}, 64'd1);
    iA = a; iB = b; iDutRes = res; iValid = 1'b1;
    @(posedge iClk);
    #1;
    c = cyc;
    iValid = 1'b0;
    iA = ~a; iB = ~b; iDutRes = ~res;
    if (push) begin
      e.done_cyc = c - 1 + lat;
      e.mm = mm; e.err = e_err; e.chk = e_chk; e.sig = e_sig;
      q.push_back(e);
    end
  endtask

  task automatic model_step(input logic [2:0] r, input logic mm);
    m_sig = {m_sig[14:0], m_sig[15] ^ m_sig[13] ^ m_sig[12] ^ m_sig[10]} ^ {13'b0, r};
    m_chk = m_chk + 16'd1;
    if (mm && m_err != 16'hFFFF) m_err = m_err + 16'd1;
  endtask

  task automatic issue_m(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] res,
                         input logic [2:0] r, input int lat, output int c);
    logic mm;
    mm = (r != res);
    model_step(r, mm);
    issue(a, b, res, lat, 1'b1, mm, m_err, m_chk, m_sig, c);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge iClk);
      n++;
    end
    check("drain_timeout", 64'(q.size()), 64'd0);
    repeat (2) @(negedge iClk);
  endtask

  // Monitor: pops one expectation per oDone, then checks counters after the CHECK edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge iClk);
      if (iRstN && oDone) begin
        if (q.size() == 0) begin
          check("unexpected_done", {63'd0, oDone}, 64'd0);
        end else begin
          e = q.pop_front();
          check("done_cycle", 64'(cyc), 64'(e.done_cyc));
          check("mismatch", {63'd0, oMismatch}, {63'd0, e.mm});
          @(posedge iClk);
          #1;
          check("err_cnt", {48'd0, oErrCnt}, {48'd0, e.err});
          check("check_cnt", {48'd0, oCheckCnt}, {48'd0, e.chk});
          check("signature", {48'd0, oSignature}, {48'd0, e.sig});
        end
      end else if (oMismatch) begin
        check("mismatch_idle", {63'd0, oMismatch}, 64'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic [W-1:0] a, b;
    logic [2:0] r;

    repeat (3) @(negedge iClk);
    #1;
    check("rst_ready", {63'd0, oReady}, 64'd1);
    check("rst_done", {63'd0, oDone}, 64'd0);
    check("rst_counts", {16'd0, oErrCnt, oCheckCnt, oSignature}, 64'd0);
    @(negedge iClk);
    iRstN = 1'b1;

    // Hand-computed directed vectors
    issue('0, '0, 3'b010, 9, 1'b1, 1'b0, 16'd0, 16'd1, 16'h0002, c);
    issue('0, W'(1), 3'b001, 9, 1'b1, 1'b0, 16'd0, 16'd2, 16'h0005, c);
    issue(W'(1) << 448, '0, 3'b100, 2, 1'b1, 1'b0, 16'd0, 16'd3, 16'h000E, c);
    @(negedge iClk);
    @(negedge iClk);
    check("ready_low_t2", {63'd0, oReady}, 64'd0);
    @(negedge iClk);
    check("ready_high_t3", {63'd0, oReady}, 64'd1);
    issue(W'(5), W'(6), 3'b100, 9, 1'b1, 1'b1, 16'd1, 16'd4, 16'h001D, c);
    issue(W'(5), W'(6), 3'b110, 9, 1'b1, 1'b1, 16'd2, 16'd5, 16'h003B, c);
    issue(W'(7) << 256, W'(2) << 256, 3'b100, 5, 1'b1, 1'b0, 16'd2, 16'd6, 16'h0072, c);
    issue('1, '1, 3'b000, 9, 1'b1, 1'b1, 16'd3, 16'd7, 16'h00E6, c);
    drain();
    m_err = 16'd3; m_chk = 16'd7; m_sig = 16'h00E6;

    // Early-exit burst drives the signature through its feedback taps
    for (int i = 0; i < 12; i++) begin
      a = W'(i + 1) << 448;
      b = (i % 2 == 1) ? '0 : (W'(100) << 448);
      r = (i % 2 == 1) ? 3'b100 : 3'b001;
      issue_m(a, b, r, r, 2, c);
    end
    drain();

    // iValid held high: captures only in IDLE, operands changing every cycle
    for (int i = 0; i < 45; i++) begin
      logic rdy;
      @(negedge iClk);
      iA = W'(i);
      iB = W'(20);
      r = (i > 20) ? 3'b100 : ((i == 20) ? 3'b010 : 3'b001);
      iDutRes = r;
      iValid = 1'b1;
      rdy = oReady;
      @(posedge iClk);
      #1;
      if (rdy) begin
        exp_t e;
        model_step(r, 1'b0);
        e.done_cyc = cyc - 1 + 9;
        e.mm = 1'b0; e.err = m_err; e.chk = m_chk; e.sig = m_sig;
        q.push_back(e);
      end
    end
    @(negedge iClk);
    iValid = 1'b0;
    drain();

    // Reset in the middle of an equal-operand check
    issue('0, '0, 3'b010, 9, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, c);
    repeat (4) @(negedge iClk);
    iRstN = 1'b0;
    #1;
    check("midrst_ready", {63'd0, oReady}, 64'd1);
    check("midrst_done", {63'd0, oDone}, 64'd0);
    check("midrst_counts", {16'd0, oErrCnt, oCheckCnt, oSignature}, 64'd0);
    @(negedge iClk);
    iRstN = 1'b1;
    m_err = '0; m_chk = '0; m_sig = '0;

    // First handshake right after reset release
    issue_m('0, W'(9), 3'b001, 3'b001, 9, c);
    drain();
    check("postrst_counts", {16'd0, oErrCnt, oCheckCnt, oSignature}, {16'd0, 16'd0, 16'd1, 16'h0001});

    // Clear coincident with CHECK wins over the update
    issue(W'(1) << 448, '0, 3'b001, 2, 1'b1, 1'b1, 16'd0, 16'd0, 16'd0, c);
    @(negedge iClk);
    @(negedge iClk);
    iClear = 1'b1;
    @(negedge iClk);
    iClear = 1'b0;
    m_err = '0; m_chk = '0; m_sig = '0;
    issue_m(W'(3) << 448, W'(3) << 448, 3'b010, 3'b010, 9, c);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
